// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and hazard FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_IDLE     = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding: picks the youngest in-flight producer of each EX source register.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  // EX/MEM is checked first so the younger result wins when both stages write the same register.
  function automatic fwd_sel_e selFor(input logic [REG_AW-1:0] rs);
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign fwd_a = selFor(ex_rs1);
  assign fwd_b = selFor(ex_rs2);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, branch flush, memory freeze and forwarding control for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  input  logic              mem_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              freeze_all,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int CW = $clog2(LOAD_STALL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  hz_state_e     r_state;
  logic [CW-1:0] r_cnt;

  logic     w_hazard;
  logic     w_luStall;
  logic     w_branch;
  fwd_sel_e w_fwdA;
  fwd_sel_e w_fwdB;

  assign w_hazard = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // The first stall cycle comes straight from the hazard compare so the hold is zero-latency.
  assign w_luStall = (r_state == HZ_LU_STALL) || ((r_state == HZ_IDLE) && w_hazard);
  assign w_branch  = branch_taken && !mem_busy;

  assign stall_pc     = !reset && w_luStall && !w_branch;
  assign stall_if_id  = !reset && w_luStall && !w_branch;
  assign bubble_id_ex = !reset && (w_luStall || w_branch);
  assign flush_if_id  = !reset && w_branch;
  assign freeze_all   = !reset && mem_busy;
  assign fwd_a        = reset ? 2'b00 : w_fwdA;
  assign fwd_b        = reset ? 2'b00 : w_fwdB;

  forward_unit #(
    .REG_AW(REG_AW)
  ) u_forward (
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (w_fwdA),
    .fwd_b        (w_fwdB)
  );

  // The IDLE cycle that detects the hazard is stall cycle one; LU_STALL covers the remaining ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= HZ_IDLE;
      r_cnt   <= '0;
    end else if (!mem_busy) begin
      if (branch_taken) begin
        r_state <= HZ_IDLE;
        r_cnt   <= '0;
      end else if (r_state == HZ_IDLE) begin
        if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
          r_state <= HZ_LU_STALL;
          r_cnt   <= CNT_LOAD;
        end
      end else if (r_cnt == CNT_LAST) begin
        r_state <= HZ_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_LAST;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCount;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else if (!mem_busy) begin
      if (w_luStall && !branch_taken) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (branch_taken) begin
        r_flushCount <= r_flushCount + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;
`endif

endmodule
